// File: rtl/crc4_frame_sequencer.sv
// ---------------------------------------------------------------------------
// crc4_frame_sequencer
//
// Walks a frame of `len` chunks through an external single-cycle CRC engine.
// The seed is latched on start, then each chunk is handed to the engine
// with the running CRC (acc) as crc_initial. The engine's registered result
// is folded back into acc. The final CRC is offered downstream through a
// valid/ready handshake.
//
// Optional feature (compile-time macro):
//   CRC_SEQ_TIMEOUT_EN - stall watchdog. It counts consecutive stalled
//                        FETCH/WAIT cycles. On reaching TIMEOUT_CYCLES it
//                        pulses crc_err for one cycle and returns to IDLE.
//                        Without the macro there is no timer, crc_err is
//                        tied low, and the block waits indefinitely.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a frame (sampled in IDLE only)
//   init_val, len     seed and chunk count, latched on start
//   abort             synchronous abort, any state
//   s_valid, s_data   chunk stream from source
//   s_ready           chunk accept (FETCH state)
//   eng_crc_en        engine enable (= s_valid while in FETCH)
//   eng_crc_initial   engine seed input (= acc)
//   eng_data          engine data input (= s_data)
//   eng_data_out      engine result
//   eng_dout_vld      engine result valid
//   crc_out           final CRC (= acc)
//   crc_valid         final CRC valid, held until crc_ready
//   crc_ready         consumer accept
//   busy              state != IDLE
//   crc_err           one-cycle pulse on watchdog abort
//
// States:
//   IDLE  | waiting for start
//   FETCH | offering s_ready, issuing a chunk to the engine on s_valid
//   WAIT  | waiting for the engine result of the issued chunk
//   DONE  | presenting crc_out with crc_valid until crc_ready
// ---------------------------------------------------------------------------
module crc4_frame_sequencer #(
    parameter int CRC_WIDTH      = 4,
    parameter int DATA_WIDTH     = 5,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CRC_WIDTH-1:0]  init_val,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  eng_crc_en,
    output logic [CRC_WIDTH-1:0]  eng_crc_initial,
    output logic [DATA_WIDTH-1:0] eng_data,
    input  logic [CRC_WIDTH-1:0]  eng_data_out,
    input  logic                  eng_dout_vld,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  crc_valid,
    input  logic                  crc_ready,
    output logic                  busy,
    output logic                  crc_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CRC_WIDTH-1:0]  acc;
    logic [LEN_WIDTH-1:0]  cnt;
    logic                  timeout_hit;

`ifdef CRC_SEQ_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer;
    logic             stalling;

    assign stalling    = ((state == S_FETCH) && !s_valid) ||
                         ((state == S_WAIT)  && !eng_dout_vld);
    assign timeout_hit = ((state == S_FETCH) || (state == S_WAIT)) &&
                         (timer == TMR_W'(TIMEOUT_CYCLES));

    // Counts only while the stall persists in the same state; any progress
    // or state change restarts the count from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (stalling && (state_nxt == state)) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort and watchdog take priority over everything.
    always_comb begin
        state_nxt = state;
        if (abort || timeout_hit) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = (len == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (s_valid) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Exit is decided on the pre-decrement count.
                    if (eng_dout_vld) begin
                        state_nxt = (cnt == LEN_WIDTH'(1)) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    if (crc_ready) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Accumulator and chunk counter. Abort or watchdog freezes both, so acc
    // keeps the last chained value of an abandoned frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (!abort && !timeout_hit) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= init_val;
                        cnt <= len;
                    end
                end
                S_WAIT: begin
                    if (eng_dout_vld) begin
                        acc <= eng_data_out;
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        s_ready    = 1'b0;
        eng_crc_en = 1'b0;
        crc_valid  = 1'b0;
        busy       = 1'b0;
        crc_err    = timeout_hit;
        unique case (state)
            S_IDLE: ;
            S_FETCH: begin
                s_ready    = 1'b1;
                eng_crc_en = s_valid;
                busy       = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                crc_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign eng_crc_initial = acc;
    assign eng_data        = s_data;
    assign crc_out         = acc;

endmodule
